// File: rtl/ifu_pkg.sv
// Purpose: shared types and constants for the instruction-fetch unit (fetch FSM states,
//          default widths and boot address, alignment helper).
// Contents: IFU_ADDR_W, IFU_INST_W, IFU_RESET_PC, fetch_state_e, pc_misaligned().
package ifu_pkg;

  localparam int          IFU_ADDR_W   = 64;
  localparam int          IFU_INST_W   = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

  // Instructions are 4-byte aligned; any set low bit in a target is a fault.
  function automatic logic pc_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// Purpose: single-entry holding register for one fetched instruction and its PC,
//          presented to decode with a valid/ready handshake.
// Ports: clk/rst; load + load_data/load_pc fill the entry; flush drops it;
//        valid/ready/data/pc form the decode-side interface (all registered).
module ifu_inst_buf
  import ifu_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int INST_W = IFU_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              flush,
  output logic              valid,
  input  logic              ready,
  output logic [INST_W-1:0] data,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (flush || (valid && ready)) begin
      // Data/pc keep their last value; only the valid flag is dropped.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; owns the fetch PC, issues one outstanding imem
//          request at a time, buffers the response for decode, applies execute redirects
//          and halts (sticky) on a misaligned redirect target.
// Ports: clk/rst (sync, active-high); imem_req_* request channel (valid/ready);
//        imem_rsp_* response (no back-pressure); inst_* decode channel (valid/ready);
//        redirect_* pulse from execute; pc_out debug PC; fetch_halt sticky fault flag.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int               ADDR_W   = IFU_ADDR_W,
  parameter int               INST_W   = IFU_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_halt
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              kill, kill_nxt;
  logic              halt, halt_nxt;
  logic              buf_load, buf_flush;
  logic              redirect_bad;

  assign redirect_bad = redirect_valid && pc_misaligned(redirect_pc[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      kill  <= 1'b0;
      halt  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
      halt  <= halt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    halt_nxt  = halt;
    buf_load  = 1'b0;
    buf_flush = 1'b0;

    case (state)
      BOOT: begin
        state_nxt = REQ;
        if (redirect_valid) pc_nxt = redirect_pc;
      end

      REQ: begin
        if (imem_req_ready) state_nxt = WAIT;
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          // Request already left for the old PC: its response must be discarded.
          if (imem_req_ready) kill_nxt = 1'b1;
        end
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = REQ;
          kill_nxt  = 1'b0;
          if (!kill && !redirect_valid) begin
            buf_load  = 1'b1;
            pc_nxt    = pc + ADDR_W'(4);
            state_nxt = HOLD;
          end
        end
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          // With the response arriving now there is nothing left to kill.
          if (!imem_rsp_valid) kill_nxt = 1'b1;
        end
      end

      HOLD: begin
        if (inst_ready) state_nxt = REQ;
        if (redirect_valid) begin
          // If inst_ready is also high, decode has taken the instruction this cycle.
          pc_nxt    = redirect_pc;
          buf_flush = 1'b1;
          state_nxt = REQ;
        end
      end

      HALT: ;

      default: state_nxt = BOOT;
    endcase

    // A misaligned target overrides everything: freeze on the faulting PC.
    if (state != HALT && redirect_bad) begin
      state_nxt = HALT;
      pc_nxt    = redirect_pc;
      halt_nxt  = 1'b1;
      kill_nxt  = 1'b0;
      buf_load  = 1'b0;
      buf_flush = 1'b1;
    end
  end

  ifu_inst_buf #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .load_data(imem_rsp_data),
    .load_pc  (pc),
    .flush    (buf_flush),
    .valid    (inst_valid),
    .ready    (inst_ready),
    .data     (inst_data),
    .pc       (inst_pc)
  );

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign pc_out         = pc;
  assign fetch_halt     = halt;

endmodule
